// File: rtl/mem_defs.sv
// Shared data-memory definitions: lane handshake state encoding and the
// default word/address widths also used by the SIMD side.
package mem_defs;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DONE    = 2'd2
  } lane_state_e;

endpackage

// File: rtl/rr_port_selector.sv
// Combinational round-robin selector: grants up to NUM_PORTS eligible lanes
// starting at rr_ptr and reports the pointer just past the last grant.
module rr_port_selector #(
  parameter int LANE_WIDTH = 16,
  parameter int NUM_PORTS  = 4,
  localparam int PTR_WIDTH = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1
) (
  input  logic [LANE_WIDTH-1:0] eligible,
  input  logic [PTR_WIDTH-1:0]  rr_ptr,
  output logic [LANE_WIDTH-1:0] grant,
  output logic [PTR_WIDTH-1:0]  next_rr_ptr
);

  int                   grant_count;
  logic [PTR_WIDTH-1:0] idx;

  always_comb begin
    grant       = '0;
    next_rr_ptr = rr_ptr;
    grant_count = 0;
    idx         = '0;
    for (int k = 0; k < LANE_WIDTH; k++) begin
      idx = PTR_WIDTH'((int'(rr_ptr) + k) % LANE_WIDTH);
      if (eligible[idx] && (grant_count < NUM_PORTS)) begin
        grant[idx]  = 1'b1;
        grant_count = grant_count + 1;
        next_rr_ptr = PTR_WIDTH'((int'(idx) + 1) % LANE_WIDTH);
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the per-lane LSU data-memory handshake: word store, per-lane
// request FSMs, round-robin port arbitration, one-cycle ack pulses.
module data_mem_responder
  import mem_defs::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LANE_WIDTH = 16,
  parameter int NUM_PORTS  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LANE_WIDTH-1:0]                mem_read_valid,
  input  logic [LANE_WIDTH-1:0]                mem_write_valid,
  input  logic [LANE_WIDTH-1:0][ADDR_WIDTH-1:0] mem_addr,
  input  logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] mem_write_data,
  output logic [LANE_WIDTH-1:0]                data_mem_ready_ack,
  output logic [LANE_WIDTH-1:0]                data_mem_write_ack,
  output logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] mem_read_data,
  input  logic                                 host_we,
  input  logic [ADDR_WIDTH-1:0]                host_addr,
  input  logic [DATA_WIDTH-1:0]                host_wdata,
  output logic                                 busy
);

  localparam int PTR_WIDTH = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] storage [DEPTH];

  lane_state_e          lane_state      [LANE_WIDTH];
  lane_state_e          lane_state_next [LANE_WIDTH];
  logic [PTR_WIDTH-1:0] scan_lane       [LANE_WIDTH];
  logic [PTR_WIDTH-1:0] rr_ptr, rr_ptr_next;
  logic [LANE_WIDTH-1:0] lane_req, eligible, grant;
  logic                  busy_next;

  assign lane_req = mem_read_valid | mem_write_valid;

  // A lane already acked stays out of arbitration until its request drops.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < LANE_WIDTH; i++) begin
      eligible[i] = lane_req[i] && (lane_state[i] != DONE) && !host_we;
    end
  end

  rr_port_selector #(
    .LANE_WIDTH (LANE_WIDTH),
    .NUM_PORTS  (NUM_PORTS)
  ) u_selector (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .next_rr_ptr (rr_ptr_next)
  );

  always_comb begin
    busy_next = 1'b0;
    for (int i = 0; i < LANE_WIDTH; i++) begin
      lane_state_next[i] = lane_state[i];
      case (lane_state[i])
        IDLE:    if (lane_req[i]) lane_state_next[i] = grant[i] ? DONE : PENDING;
        PENDING: if (grant[i]) lane_state_next[i] = DONE;
        DONE:    if (!lane_req[i]) lane_state_next[i] = IDLE;
        default: lane_state_next[i] = IDLE;
      endcase
      if (lane_state_next[i] == PENDING) busy_next = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < LANE_WIDTH; k++) begin
      scan_lane[k] = PTR_WIDTH'((int'(rr_ptr) + k) % LANE_WIDTH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANE_WIDTH; i++) lane_state[i] <= IDLE;
      rr_ptr             <= '0;
      busy               <= 1'b0;
      data_mem_ready_ack <= '0;
      data_mem_write_ack <= '0;
      mem_read_data      <= '0;
    end else begin
      for (int i = 0; i < LANE_WIDTH; i++) begin
        lane_state[i] <= lane_state_next[i];
        if (grant[i] && mem_read_valid[i] && !mem_write_valid[i]) begin
          mem_read_data[i] <= storage[mem_addr[i]];
        end
      end
      rr_ptr             <= rr_ptr_next;
      busy               <= busy_next;
      data_mem_ready_ack <= grant & mem_read_valid & ~mem_write_valid;
      data_mem_write_ack <= grant & mem_write_valid;
    end
  end

  // Walk scan order backwards so the earliest-scanned writer lands last and wins.
  always_ff @(posedge clk) begin
    if (host_we) storage[host_addr] <= host_wdata;
    for (int k = LANE_WIDTH - 1; k >= 0; k--) begin
      if (grant[scan_lane[k]] && mem_write_valid[scan_lane[k]]) begin
        storage[mem_addr[scan_lane[k]]] <= mem_write_data[scan_lane[k]];
      end
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the per-lane data-memory handshake driven by the SIMD unit's 16 LSUs.
- Owns a word-addressed data store of 2^ADDR_WIDTH words.
- Accepts lane read/write requests and serves up to NUM_PORTS lanes per cycle, chosen by round-robin.
- Returns one-cycle ack pulses, and read data for reads; a host port preloads and modifies memory.

Parameters:
DATA_WIDTH, 64, word width
ADDR_WIDTH, 7, word address width; depth = 2^ADDR_WIDTH
LANE_WIDTH, 16, number of requesting lanes
NUM_PORTS, 4, max lane accesses served per cycle (1..LANE_WIDTH)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
mem_read_valid  in  LANE_WIDTH  per-lane read request, held until ack
mem_write_valid  in  LANE_WIDTH  per-lane write request, held until ack
mem_addr  in  ADDR_WIDTH x LANE_WIDTH  per-lane word address
mem_write_data  in  DATA_WIDTH x LANE_WIDTH  per-lane write data
data_mem_ready_ack  out  LANE_WIDTH  per-lane read-complete pulse
data_mem_write_ack  out  LANE_WIDTH  per-lane write-complete pulse
mem_read_data  out  DATA_WIDTH x LANE_WIDTH  per-lane read data, registered
host_we  in  1  host write strobe
host_addr  in  ADDR_WIDTH  host word address
host_wdata  in  DATA_WIDTH  host write data
busy  out  1  high when any lane is in PENDING state (requesting, not yet served)

Behaviour:
- Reset (rst low, async):
  - acks = 0, mem_read_data = 0, busy = 0, rr_ptr = 0, all lane states IDLE.
  - Storage is not cleared.
  - In-flight requests are dropped; the lane must re-request after reset.
- Per-lane FSM:
  - IDLE -> PENDING when (read_valid | write_valid).
  - PENDING -> DONE on grant.
  - DONE -> IDLE when read_valid = 0 and write_valid = 0.
  - A lane in DONE is never granted, so a request still held high in the cycle after its ack is not served twice.
  - The IDLE->PENDING transition and grant eligibility use the combinational request, so a new request can be granted in its first cycle.
- Grant, combinational in cycle N:
  - Scan lanes in order rr_ptr, rr_ptr+1, ... modulo LANE_WIDTH.
  - Grant the first NUM_PORTS lanes that request and are not in DONE.
  - If host_we = 1, no lane is granted in that cycle.
- Edge ending cycle N:
  - Granted writes update storage.
  - Granted reads capture the storage value present before this edge into mem_read_data[i].
  - Matching ack bits assert in cycle N+1 for exactly one cycle; latency is request-to-ack = 1 cycle when not stalled.
- rr_ptr:
  - Becomes (last granted lane + 1) mod LANE_WIDTH.
  - Unchanged when nothing is granted.
- mem_read_data[i] holds its value until lane i's next granted read.
- Both valids high on one lane: treated as a write; only data_mem_write_ack pulses and mem_read_data is unchanged.
- Same-cycle conflicts:
  - Two granted writes to the same address: the lane earlier in rr scan order wins.
  - A read and a write to the same address: the read returns the old value.
  - A host write and a lane read cannot coincide, because host_we blocks all lane grants.
- Address width: mem_addr is used unextended; no out-of-range case exists.
- busy = OR of lane PENDING, registered with the state.

Decomposition:
- Shared package mem_defs:
  - lane state encoding IDLE/PENDING/DONE (2-bit typedef);
  - default DATA_WIDTH and ADDR_WIDTH constants, shared with the SIMD side.
- Sub-module rr_port_selector (combinational):
  - inputs: eligible mask, rr_ptr;
  - outputs: grant mask of up to NUM_PORTS bits and next rr_ptr.
- The top level holds the storage array, lane FSMs and output registers.

Test Plan:
- Host writes 0xDEAD_BEEF to addr 5; lane 3 reads addr 5 → data_mem_ready_ack[3] pulses one cycle later; mem_read_data[3] = 0xDEAD_BEEF and stays stable afterward.
- All 16 lanes read at once, NUM_PORTS = 4, rr_ptr = 0 → acks for lanes 0-3, 4-7, 8-11, 12-15 in four consecutive cycles; busy drops after the last grant.
- Lane 2 holds write_valid for 3 cycles after its ack → exactly one write_ack pulse; a second request after valid drops is served again.
- Lanes 1 and 6 both write addr 9, with 0x11 and 0x66 respectively, rr_ptr = 0 → memory[9] = 0x11; a read of addr 9 issued the same cycle returns the old value.
- host_we held for 2 cycles while lane 0 reads → lane 0's ack is delayed 2 cycles and still pulses exactly once.
- rst asserted while 8 lanes are PENDING → all acks 0 immediately; after release with requests held, all 8 lanes are served once, starting at lane 0.
